// File: rtl/seq_mult4_shift_add.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
// One ripple-carry adder is reused across four iterations. Operands
// arrive on a valid/ready handshake and the 8-bit product leaves on a
// second valid/ready handshake.

// 4-bit ripple-carry adder. Adds x + y + cin and returns a 4-bit sum
// with a carry out. The multiplier below uses it with cin tied low.
module fourbitadder (
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [4:0] w_carry;

    assign w_carry[0] = i_cin;

    // One full adder per bit; the carry ripples from bit 0 up to bit 3.
    for (genvar g = 0; g < 4; g++) begin : gFullAdder
        assign o_sum[g]       = i_x[g] ^ i_y[g] ^ w_carry[g];
        assign w_carry[g + 1] = (i_x[g] & i_y[g])
                              | (i_x[g] & w_carry[g])
                              | (i_y[g] & w_carry[g]);
    end

    assign o_cout = w_carry[4];

endmodule

// Multiplier top level. The partial product lives in {hi, lo}: hi
// accumulates the multiplicand, lo starts as the multiplier and is
// shifted out one bit per iteration while the product shifts in.
module seq_mult4_shift_add #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    // The datapath is built around a single 4-bit adder, so any other
    // operand width is rejected at elaboration time.
    if (WIDTH != 4) begin : gBadWidth
        $error("seq_mult4_shift_add: WIDTH must be 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last iteration index: four iterations, counted 0..3.
    localparam logic [2:0] LAST_ITER = 3'd3;

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [2:0]           r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    state_t               w_stateNext;
    logic [WIDTH-1:0]     w_mcandNext;
    logic [WIDTH-1:0]     w_hiNext;
    logic [WIDTH-1:0]     w_loNext;
    logic [2:0]           w_cntNext;
    logic [2*WIDTH-1:0]   w_productNext;

    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic [2*WIDTH-1:0]   w_shifted;

    // Shared adder: hi + mcand. The carry out is the ninth bit of the
    // partial product, so it is never lost before the shift.
    fourbitadder uAdder (
        .i_x    (r_hi),
        .i_y    (r_mcand),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Next partial product: add the multiplicand when the current
    // multiplier bit is set, then shift the 9-bit value right by one.
    always_comb begin
        if (r_lo[0]) begin
            w_shifted = {w_cout, w_sum, r_lo[WIDTH-1:1]};
        end else begin
            w_shifted = {1'b0, r_hi, r_lo[WIDTH-1:1]};
        end
    end

    // Next-state, datapath-load and handshake decode. Every output is
    // defaulted first so that each state only names what it changes.
    always_comb begin
        w_stateNext   = r_state;
        w_mcandNext   = r_mcand;
        w_hiNext      = r_hi;
        w_loNext      = r_lo;
        w_cntNext     = r_cnt;
        w_productNext = r_product;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b0;

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_mcandNext = a;
                    w_hiNext    = '0;
                    w_loNext    = b;
                    w_cntNext   = 3'd0;
                    w_stateNext = S_RUN;
                end
            end

            S_RUN: begin
                busy      = 1'b1;
                w_hiNext  = w_shifted[2*WIDTH-1:WIDTH];
                w_loNext  = w_shifted[WIDTH-1:0];
                w_cntNext = r_cnt + 3'd1;
                if (r_cnt == LAST_ITER) begin
                    w_productNext = w_shifted;
                    w_stateNext   = S_DONE;
                end
            end

            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_stateNext = S_IDLE;
                end
            end

            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset is synchronous and discards
    // any operation that is in flight, including the held product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= 3'd0;
            r_product <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_mcand   <= w_mcandNext;
            r_hi      <= w_hiNext;
            r_lo      <= w_loNext;
            r_cnt     <= w_cntNext;
            r_product <= w_productNext;
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_seq_mult4_shift_add.sv
// Self-checking bench for seq_mult4_shift_add. Expected products are
// computed by the bench and queued when an operand pair is accepted,
// then popped and compared when the result handshake completes.
module tb_seq_mult4_shift_add;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] product;
    logic       busy;

    int checkCount = 0;
    int passCount  = 0;
    int violations = 0;

    logic [7:0] expQ[$];

    seq_mult4_shift_add #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A product must never be offered while the block reports idle.
    always @(negedge clk) begin
        if (rst_n && out_valid && !busy) begin
            violations++;
        end
    end

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, present one operand pair for a single edge and
    // queue its expected product.
    task automatic issue(input logic [3:0] ia, input logic [3:0] ib);
        int n;
        logic [7:0] e;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checkCount++;
        if (!in_ready) begin
            $display("[TB] FAIL issue_timeout: in_ready=%b required 1", in_ready);
        end else begin
            passCount++;
            e = {4'd0, ia} * {4'd0, ib};
            a        = ia;
            b        = ib;
            in_valid = 1'b1;
            expQ.push_back(e);
            tick();
            in_valid = 1'b0;
        end
    endtask

    // Wait for out_valid, stall the consumer for a number of cycles,
    // then complete the handshake and return the product seen.
    task automatic collect(input int stall, output logic [7:0] got, output bit timedOut);
        int n;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        timedOut = !out_valid;
        repeat (stall) tick();
        got       = product;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        rst_n = 1'b1;
        checkCount++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            $display("[TB] FAIL reset_flags: got in_ready/out_valid/busy=%b required 100",
                     {in_ready, out_valid, busy});
        end else passCount++;
        checkCount++;
        if (product !== 8'h00) begin
            $display("[TB] FAIL reset_product: got %h required 00", product);
        end else passCount++;
    endtask

    task automatic test_latency();
        int n;
        logic [7:0] e;
        out_ready = 1'b1;
        issue(4'd15, 4'd15);
        n = 0;
        while (!out_valid && n < 20) begin
            checkCount++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                $display("[TB] FAIL run_flags: got busy=%b in_ready=%b required 1/0", busy, in_ready);
            end else passCount++;
            tick();
            n++;
        end
        checkCount++;
        if (n !== 4) begin
            $display("[TB] FAIL latency: got %0d cycles required 4", n);
        end else passCount++;
        e = expQ.pop_front();
        checkCount++;
        if (product !== e || e !== 8'hE1) begin
            $display("[TB] FAIL product_15x15: got %h required %h", product, e);
        end else passCount++;
        tick();
        out_ready = 1'b0;
        checkCount++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            $display("[TB] FAIL return_idle: got in_ready/out_valid/busy=%b required 100",
                     {in_ready, out_valid, busy});
        end else passCount++;
    endtask

    task automatic test_basic();
        logic [3:0] ta[3] = '{4'd9, 4'd0, 4'd7};
        logic [3:0] tb[3] = '{4'd6, 4'd13, 4'd0};
        logic [7:0] got;
        logic [7:0] e;
        bit timedOut;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i]);
            collect(0, got, timedOut);
            e = expQ.pop_front();
            checkCount++;
            if (timedOut || got !== e) begin
                $display("[TB] FAIL basic_%0d: got %h (timeout=%b) required %h", i, got, timedOut, e);
            end else passCount++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [7:0] e;
        issue(4'd5, 4'd11);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        e = expQ.pop_front();
        for (int i = 0; i < 4; i++) begin
            checkCount++;
            if (out_valid !== 1'b1 || product !== e) begin
                $display("[TB] FAIL hold_%0d: got valid=%b product=%h required 1/%h",
                         i, out_valid, product, e);
            end else passCount++;
            if (i < 3) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkCount++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 8'h37) begin
            $display("[TB] FAIL after_handshake: got ready=%b valid=%b product=%h required 1/0/37",
                     in_ready, out_valid, product);
        end else passCount++;
    endtask

    task automatic test_ignore_in_valid();
        logic [7:0] got;
        logic [7:0] e;
        bit timedOut;
        int extra;
        issue(4'd2, 4'd2);
        a        = 4'd3;
        b        = 4'd3;
        in_valid = 1'b1;
        checkCount++;
        if (in_ready !== 1'b0) begin
            $display("[TB] FAIL ready_in_run: got %b required 0", in_ready);
        end else passCount++;
        tick();
        in_valid = 1'b0;
        collect(0, got, timedOut);
        e = expQ.pop_front();
        checkCount++;
        if (timedOut || got !== e) begin
            $display("[TB] FAIL product_2x2: got %h (timeout=%b) required %h", got, timedOut, e);
        end else passCount++;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) extra++;
            tick();
        end
        checkCount++;
        if (extra !== 0) begin
            $display("[TB] FAIL second_result: got %0d valid cycles required 0", extra);
        end else passCount++;
    endtask

    task automatic test_mid_run_reset();
        logic [7:0] got;
        logic [7:0] e;
        logic [7:0] dropped;
        bit timedOut;
        issue(4'd9, 4'd9);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dropped = expQ.pop_back();
        checkCount++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== 8'h00) begin
            $display("[TB] FAIL mid_run_reset: got rdy/vld/busy=%b product=%h required 100/00 (dropped %h)",
                     {in_ready, out_valid, busy}, product, dropped);
        end else passCount++;
        issue(4'd4, 4'd4);
        collect(1, got, timedOut);
        e = expQ.pop_front();
        checkCount++;
        if (timedOut || got !== e || e !== 8'h10) begin
            $display("[TB] FAIL product_4x4: got %h (timeout=%b) required %h", got, timedOut, e);
        end else passCount++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        logic [7:0] e;
        bit timedOut;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                issue(ia[3:0], ib[3:0]);
                collect($urandom_range(0, 2), got, timedOut);
                e = expQ.pop_front();
                checkCount++;
                if (timedOut || got !== e) begin
                    $display("[TB] FAIL exhaustive_%0dx%0d: got %h (timeout=%b) required %h",
                             ia, ib, got, timedOut, e);
                end else passCount++;
            end
        end
        checkCount++;
        if (violations !== 0) begin
            $display("[TB] FAIL valid_while_idle: got %0d violations required 0", violations);
        end else passCount++;
        checkCount++;
        if (expQ.size() !== 0) begin
            $display("[TB] FAIL scoreboard_drain: got %0d entries required 0", expQ.size());
        end else passCount++;
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        test_reset();
        test_latency();
        test_basic();
        test_backpressure();
        test_ignore_in_valid();
        test_mid_run_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
